// File: rtl/eth_frame_transmitter.sv
// Avalon-ST replay of buffered Ethernet frames with runt zero-padding; first beat two cycles after a frame completes.
// Show-ahead FIFO feeds the stream; ready=0 freezes every stream output, writes into a full FIFO are dropped.

module eth_frame_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_dat,
    input  logic         wr_vld,
    output logic         full,
    output logic [W-1:0] rd_dat,
    output logic         rd_vld,
    input  logic         rd_pop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    // Full comes from the registered count, so a same-cycle pop never makes room.
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign push   = wr_vld && !full;
    assign pop    = rd_pop && rd_vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end
endmodule

module eth_frame_transmitter #(
    parameter int DEPTH     = 16,
    parameter int MIN_WORDS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic        wr_last,
    input  logic [1:0]  wr_empty,
    input  logic        wr_error,
    output logic        wr_full,
    input  logic        ready,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        sop,
    output logic        eop,
    output logic [1:0]  empty,
    output logic        error,
    output logic        busy,
    output logic [31:0] frames_sent
);
    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic [1:0]  emp;
        logic        err;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

    localparam int WW = $clog2(MIN_WORDS + 1);
    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [WW-1:0] WIDX_LAST = WW'(MIN_WORDS - 1);
    localparam logic [WW-1:0] WIDX_SAT  = WW'(MIN_WORDS);

    state_t        state_q, state_d;
    logic [WW-1:0] widx_q, widx_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          err_lat_q, err_lat_d;
    logic [31:0]   sent_q, sent_d;

    entry_t        wr_ent, head;
    logic          head_vld, push, pop;
    logic          head_eop, head_runt;
    logic [31:0]   pad_mask;

    assign wr_ent.dat  = wr_data;
    assign wr_ent.last = wr_last;
    assign wr_ent.emp  = wr_last ? wr_empty : 2'b00;
    assign wr_ent.err  = wr_last & wr_error;

    eth_frame_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_dat (wr_ent),
        .wr_vld (wr_en),
        .full   (wr_full),
        .rd_dat (head),
        .rd_vld (head_vld),
        .rd_pop (pop)
    );

    assign push      = wr_en && !wr_full;
    assign head_eop  = head.last && (widx_q >= WIDX_LAST);
    assign head_runt = head.last && (widx_q < WIDX_LAST);
    // A runt's last word loses its invalid tail bytes since the pad beats follow it.
    assign pad_mask  = 32'hFFFF_FFFF << {head.emp, 3'b000};

    always_comb begin
        pend_d = pend_q;
        if ((push && wr_last) && !(pop && head.last)) begin
            pend_d = pend_q + PW'(1);
        end else if (!(push && wr_last) && (pop && head.last)) begin
            pend_d = pend_q - PW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        err_lat_d = err_lat_q;
        sent_d    = sent_q;
        pop       = 1'b0;
        valid     = 1'b0;
        data_out  = 32'd0;
        sop       = 1'b0;
        eop       = 1'b0;
        empty     = 2'b00;
        error     = 1'b0;
        case (state_q)
            IDLE: begin
                // A full FIFO with no complete frame means an oversize frame: cut through.
                if (pend_q != '0 || wr_full) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                valid    = head_vld;
                data_out = head_runt ? (head.dat & pad_mask) : head.dat;
                sop      = head_vld && (widx_q == '0);
                if (head_eop) begin
                    eop   = head_vld;
                    empty = head_vld ? head.emp : 2'b00;
                    error = head_vld && head.err;
                end
                if (head_vld && ready) begin
                    pop = 1'b1;
                    if (head_eop) begin
                        state_d = IDLE;
                        widx_d  = '0;
                        sent_d  = sent_q + 32'd1;
                    end else if (head_runt) begin
                        state_d   = PAD;
                        widx_d    = widx_q + WW'(1);
                        err_lat_d = head.err;
                    end else if (widx_q != WIDX_SAT) begin
                        widx_d = widx_q + WW'(1);
                    end
                end
            end
            PAD: begin
                valid = 1'b1;
                eop   = (widx_q == WIDX_LAST);
                error = eop && err_lat_q;
                if (ready) begin
                    if (eop) begin
                        state_d   = IDLE;
                        widx_d    = '0;
                        err_lat_d = 1'b0;
                        sent_d    = sent_q + 32'd1;
                    end else begin
                        widx_d = widx_q + WW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            widx_q    <= '0;
            pend_q    <= '0;
            err_lat_q <= 1'b0;
            sent_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            pend_q    <= pend_d;
            err_lat_q <= err_lat_d;
            sent_q    <= sent_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign frames_sent = sent_q;
endmodule

// File: tb/tb_eth_frame_transmitter.sv
// Directed bench for eth_frame_transmitter: reset, long, runt, backpressure, oversize, error and mid-frame reset frames.
module tb_eth_frame_transmitter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_en, wr_last, wr_error;
    logic [1:0]  wr_empty;
    logic        wr_full;
    logic        ready;
    logic [31:0] data_out;
    logic        valid, sop, eop, error, busy;
    logic [1:0]  empty;
    logic [31:0] frames_sent;

    always #5 clk = ~clk;

    eth_frame_transmitter #(.DEPTH(16), .MIN_WORDS(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_last     (wr_last),
        .wr_empty    (wr_empty),
        .wr_error    (wr_error),
        .wr_full     (wr_full),
        .ready       (ready),
        .data_out    (data_out),
        .valid       (valid),
        .sop         (sop),
        .eop         (eop),
        .empty       (empty),
        .error       (error),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rdy_tog = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] bdat[$];
    bit          bsop[$];
    bit          beop[$];
    bit          berr[$];
    logic [1:0]  bemp[$];
    int          bcyc[$];
    logic [31:0] edat[$];
    int          unstable = 0;
    int          bubbles  = 0;
    bit          stalled  = 1'b0;
    logic [36:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (valid && ready) begin
                bdat.push_back(data_out);
                bsop.push_back(sop);
                beop.push_back(eop);
                berr.push_back(error);
                bemp.push_back(empty);
                bcyc.push_back(cyc);
            end
            if (stalled && valid && ({data_out, sop, eop, empty, error} !== held)) unstable++;
            stalled = valid && !ready;
            held    = {data_out, sop, eop, empty, error};
            if (busy && !valid) bubbles++;
        end
    end

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_tog) ready = ~ready;
            else         ready = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrq();
        bdat.delete(); bsop.delete(); beop.delete(); berr.delete();
        bemp.delete(); bcyc.delete(); edat.delete();
        unstable = 0;
        bubbles  = 0;
    endtask

    task automatic wr(input logic [31:0] d, input bit last, input logic [1:0] e, input bit er);
        int n = 0;
        while (wr_full === 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("wr_full_stuck", 32'(wr_full), 32'd0);
        wr_data  = d;
        wr_last  = last;
        wr_empty = e;
        wr_error = er;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        wr_empty = 2'b00;
        wr_error = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int n);
        int k = 0;
        while (frames_sent !== 32'(n) && k < 400) begin
            tick();
            k++;
        end
        chk(tag, frames_sent, 32'(n));
    endtask

    // Compares captured beats against edat: sop only first, eop only last, error only at errbeat.
    task automatic chk_beats(input string tag, input logic [1:0] elast, input int errbeat);
        int n    = (bdat.size() < edat.size()) ? bdat.size() : edat.size();
        int last = edat.size() - 1;
        int es = 0, ee = 0, er = 0, em = 0;
        chk({tag, "_nbeats"}, 32'(bdat.size()), 32'(edat.size()));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_d%0d", tag, i), bdat[i], edat[i]);
            if (bsop[i] != (i == 0)) es++;
            if (beop[i] != (i == last)) ee++;
            if (berr[i] != (i == errbeat)) er++;
            if (bemp[i] !== ((i == last) ? elast : 2'b00)) em++;
        end
        chk({tag, "_sop"}, 32'(es), 32'd0);
        chk({tag, "_eop"}, 32'(ee), 32'd0);
        chk({tag, "_err"}, 32'(er), 32'd0);
        chk({tag, "_empty"}, 32'(em), 32'd0);
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] acc2;
        int t15, t, ta, aeop, k;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_empty = 2'b00; wr_error = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sop_eop_err", 32'({sop, eop, error}), 32'd0);
        chk("rst_empty", 32'(empty), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_sent", frames_sent, 32'd0);
        chk("rst_full", 32'(wr_full), 32'd0);
        acc = '0; acc2 = '0;
        for (int i = 0; i < 8; i++) begin
            acc  = acc | {24'd0, valid, sop, eop, error, busy, empty, wr_full};
            acc2 = acc2 | data_out | frames_sent;
            tick();
        end
        chk("idle_ctrl", acc, 32'd0);
        chk("idle_data", acc2, 32'd0);

        // 20-word frame, cut-through once the FIFO fills
        clrq();
        t15 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 15) t15 = cyc;
            wr(32'(i), i == 19, 2'd2, 1'b0);
            edat.push_back(32'(i));
        end
        wait_sent("t2_sent", 1);
        chk_beats("t2", 2'd2, -1);
        if (bcyc.size() == 20) begin
            chk("t2_sop_cyc", 32'(bcyc[0]), 32'(t15 + 2));
            chk("t2_span", 32'(bcyc[19] - bcyc[0]), 32'd19);
        end else chk("t2_have20", 32'(bcyc.size()), 32'd20);

        // 5-word runt padded to 15 beats
        clrq();
        t = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) t = cyc;
            wr({4{4'(i), 4'(i)}}, i == 5, 2'd3, 1'b0);
        end
        edat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55000000};
        for (int i = 0; i < 10; i++) edat.push_back(32'd0);
        wait_sent("t3_sent", 2);
        chk_beats("t3", 2'd0, -1);
        if (bcyc.size() == 15) begin
            chk("t3_sop_cyc", 32'(bcyc[0]), 32'(t + 2));
            chk("t3_span", 32'(bcyc[14] - bcyc[0]), 32'd14);
        end else chk("t3_have15", 32'(bcyc.size()), 32'd15);
        chk("t3_idle", 32'(busy), 32'd0);

        // ready toggling every cycle
        clrq();
        rdy_tog = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(32'(i), i == 19, 2'd2, 1'b0);
            edat.push_back(32'(i));
        end
        wait_sent("t4_sent", 3);
        rdy_tog = 1'b0;
        tick();
        chk_beats("t4", 2'd2, -1);
        chk("t4_stable", 32'(unstable), 32'd0);

        // 24-word oversize frame; writes while full are dropped
        clrq();
        for (int i = 0; i < 24; i++) begin
            if (i == 16) begin
                chk("t5_full", 32'(wr_full), 32'd1);
                wr_data = 32'hDEADBEEF; wr_last = 1'b1; wr_en = 1'b1;
                tick();
                tick();
                wr_en = 1'b0; wr_last = 1'b0;
                tick();
            end else if (i > 16) begin
                repeat (3) tick();
            end
            wr(32'hA000_0000 + 32'(i), i == 23, 2'd0, 1'b0);
            edat.push_back(32'hA000_0000 + 32'(i));
        end
        wait_sent("t5_sent", 4);
        chk_beats("t5", 2'd0, -1);
        chk("t5_bubbles", 32'(bubbles != 0), 32'd1);

        // errored runt, with next frame's last write coinciding with its last-word pop
        clrq();
        ta = cyc;
        wr(32'hC1C1C1C1, 1'b0, 2'd0, 1'b0);
        wr(32'hC2C2C2C2, 1'b0, 2'd0, 1'b0);
        wr(32'hC3C3C3C3, 1'b1, 2'd0, 1'b1);
        repeat (3) tick();
        wr(32'hB0B0B0B0, 1'b1, 2'd0, 1'b0);
        chk("t6_pending", 32'(dut.pend_q), 32'd1);
        if (bcyc.size() >= 3) chk("t6_pop_cyc", 32'(bcyc[2]), 32'(ta + 6));
        else chk("t6_have3", 32'(bcyc.size()), 32'd3);
        edat = '{32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
        for (int i = 0; i < 12; i++) edat.push_back(32'd0);
        wait_sent("t6a_sent", 5);
        chk_beats("t6a", 2'd0, 14);
        aeop = (bcyc.size() > 0) ? bcyc[bcyc.size() - 1] : 0;
        clrq();
        edat.push_back(32'hB0B0B0B0);
        for (int i = 0; i < 14; i++) edat.push_back(32'd0);
        wait_sent("t6b_sent", 6);
        chk_beats("t6b", 2'd0, -1);
        if (bcyc.size() > 0) chk("t6_gap", 32'(bcyc[0]), 32'(aeop + 2));
        tick();
        chk("t6_idle", 32'(busy), 32'd0);

        // reset on beat 6 of a 20-word frame
        clrq();
        for (int i = 0; i < 20; i++) wr(32'hD000_0000 + 32'(i), i == 19, 2'd0, 1'b0);
        k = 0;
        while (bdat.size() < 6 && k < 200) begin
            tick();
            k++;
        end
        chk("t7_at_beat6", 32'(bdat.size()), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_valid", 32'(valid), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_sent", frames_sent, 32'd0);
        chk("t7_full", 32'(wr_full), 32'd0);
        repeat (30) tick();
        chk("t7_nbeats", 32'(bdat.size()), 32'd7);
        k = 0;
        foreach (beop[i]) if (beop[i]) k++;
        chk("t7_no_eop", 32'(k), 32'd0);
        chk("t7_sent_after", frames_sent, 32'd0);
        chk("t7_still_idle", 32'({valid, busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
